seq_sub_64bit: RTL and testbench
================================

Name: seq_sub_64bit

Overview:
Multi-cycle 64-bit subtractor computing diff = a - b - bin, one 16-bit chunk per clock, least-significant chunk first. The borrow ripples between chunks through a register. It is the subtract counterpart to the combinational ripple-carry add path and serves datapaths that need a - b with a registered start/done handshake. Each chunk uses two's-complement add: a_chunk + ~b_chunk + ~borrow_in.

Parameters:
WIDTH, 64, operand/result width; must be an integer multiple of CHUNK
CHUNK, 16, bits processed per clock
NCHUNK, WIDTH/CHUNK (derived localparam, 4), number of RUN cycles per operation

Ports:
clk  input  1  rising-edge clock (only clock)
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when state is IDLE or DONE
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
bin  input  1  borrow-in; captured on accepted start
diff  output  WIDTH  result; registered; held until next accepted start
bout  output  1  final borrow-out (1 when a < b + bin, unsigned)
ovf  output  1  signed overflow of a - b - bin
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when diff/bout/ovf become valid

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; diff=0, bout=0, ovf=0, busy=0, done=0; chunk index=0; captured operands cleared. Reset has priority over everything and aborts any operation in flight; no done pulse follows.
- FSM states are IDLE, RUN and DONE.
- IDLE: if start=1, capture a, b, bin. Set borrow register=bin, index=0, busy=1, diff=0, go to RUN. Otherwise hold.
- RUN: each edge processes chunk[index], written as {c, d} = a_chunk + ~b_chunk + ~borrow.
  - Write d into diff[index*CHUNK +: CHUNK].
  - Set borrow = ~c.
  - Increment index.
  - On the edge that processes index NCHUNK-1, go to DONE: busy=0, done=1, bout=final borrow, ovf=(a[MSB]!=b[MSB]) && (diff_final[MSB]!=a[MSB]).
  - start is ignored during RUN; captured operands do not change when the inputs a, b or bin change.
- DONE: lasts exactly one cycle with done=1.
  - If start=1 in this cycle, it is accepted exactly as in IDLE (back-to-back operation). done drops to 0 and busy rises to 1.
  - Otherwise go to IDLE with done=0.
- Latency: the accepting edge is E0. Chunks are processed on E1..E4, and done is high in the cycle after E4. That is NCHUNK+1 edges from start to the done cycle. Throughput is one operation per NCHUNK+1 cycles.
- diff, bout and ovf change only on an accepting edge (diff cleared; bout and ovf hold their old values until completion) or during RUN/completion. They remain stable after done until the next accepted start.
- Intermediate diff chunks are visible during RUN. Consumers sample diff only when done=1 or later.
- Arithmetic is modulo 2^WIDTH. The borrow crosses chunk boundaries only via the borrow register, never combinationally.
- start held high continuously gives back-to-back operations: it is accepted in IDLE or DONE and ignored in RUN.

Test Plan:
- After reset, a=5, b=3, bin=0, start pulse → done in the 5th cycle after acceptance; diff=0x0000000000000002, bout=0, ovf=0; busy high for exactly 4 cycles.
- a=0, b=1, bin=0 → diff=0xFFFFFFFFFFFFFFFF, bout=1, ovf=0 (borrow ripples through all 4 chunks).
- a=0x8000000000000000, b=1, bin=0 → diff=0x7FFFFFFFFFFFFFFF, bout=0, ovf=1. Also a=0x7FFFFFFFFFFFFFFF, b=0xFFFFFFFFFFFFFFFF → diff=0x8000000000000000, ovf=1, bout=1.
- Start an operation (a=10, b=4). Two cycles later pulse start with a=100, b=1 and change the a/b inputs → second start ignored; result diff=6, exactly one done pulse.
- Assert rst for one cycle during RUN (after 2 chunks) → next cycle diff=0, busy=0, done=0, no done pulse. A new start with a=7, b=7 then yields diff=0, bout=0.
- Assert start in the DONE cycle of a prior operation with a=0x10000, b=0x1, bin=1 → accepted with no idle gap; diff=0x000000000000FFFE, bout=0, ovf=0 (borrow crosses the chunk0→chunk1 boundary).

Source files
------------

// File: rtl/seq_sub_64bit.sv
// Multi-cycle subtractor: diff = a - b - bin, one CHUNK-bit slice per clock, LSB slice first.
// The borrow between slices lives only in a register; results are held until the next accepted start.
module seq_sub_64bit #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int OFSW   = $clog2(WIDTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r, state_n;
  logic [WIDTH-1:0]  a_r, a_n;
  logic [WIDTH-1:0]  b_r, b_n;
  logic [WIDTH-1:0]  diff_r, diff_n;
  logic              borrow_r, borrow_n;
  logic [IDXW-1:0]   idx_r, idx_n;
  logic              bout_r, bout_n;
  logic              ovf_r, ovf_n;
  logic              busy_r, busy_n;
  logic              done_r, done_n;

  logic [OFSW-1:0]   ofs_s;
  logic [CHUNK:0]    sum_s;

  // Current slice: a + ~b + ~borrow, so the carry out is the inverted borrow out.
  assign ofs_s = OFSW'(idx_r) * OFSW'(CHUNK);
  assign sum_s = {1'b0, a_r[ofs_s +: CHUNK]} + {1'b0, ~b_r[ofs_s +: CHUNK]}
               + {{CHUNK{1'b0}}, ~borrow_r};

  // Next-state and datapath update logic.
  always_comb begin
    state_n  = state_r;
    a_n      = a_r;
    b_n      = b_r;
    diff_n   = diff_r;
    borrow_n = borrow_r;
    idx_n    = idx_r;
    bout_n   = bout_r;
    ovf_n    = ovf_r;
    busy_n   = busy_r;
    done_n   = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          a_n      = a;
          b_n      = b;
          borrow_n = bin;
          idx_n    = {IDXW{1'b0}};
          diff_n   = {WIDTH{1'b0}};
          busy_n   = 1'b1;
          state_n  = RUN;
        end else begin
          busy_n   = 1'b0;
          state_n  = IDLE;
        end
      end
      RUN: begin
        diff_n[ofs_s +: CHUNK] = sum_s[CHUNK-1:0];
        borrow_n = ~sum_s[CHUNK];
        if (idx_r == LAST_IDX) begin
          // Top slice: its MSB is the result sign used for overflow.
          idx_n   = {IDXW{1'b0}};
          busy_n  = 1'b0;
          done_n  = 1'b1;
          bout_n  = ~sum_s[CHUNK];
          ovf_n   = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (sum_s[CHUNK-1] != a_r[WIDTH-1]);
          state_n = DONE;
        end else begin
          idx_n   = idx_r + IDXW'(1);
        end
      end
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      diff_r   <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      idx_r    <= {IDXW{1'b0}};
      bout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      a_r      <= a_n;
      b_r      <= b_n;
      diff_r   <= diff_n;
      borrow_r <= borrow_n;
      idx_r    <= idx_n;
      bout_r   <= bout_n;
      ovf_r    <= ovf_n;
      busy_r   <= busy_n;
      done_r   <= done_n;
    end
  end

  assign diff = diff_r;
  assign bout = bout_r;
  assign ovf  = ovf_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_seq_sub_64bit.sv
// Directed self-checking bench for seq_sub_64bit: latency, borrow ripple, overflow,
// start-during-RUN, mid-operation reset and back-to-back starts.
module tb_seq_sub_64bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] a;
  logic [63:0] b;
  logic        bin;
  logic [63:0] diff;
  logic        bout;
  logic        ovf;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  seq_sub_64bit dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .diff (diff),
    .bout (bout),
    .ovf  (ovf),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called right after the accepting edge; returns edges until done and busy cycles seen.
  task automatic wait_done(output int edges, output int busy_cnt);
    edges = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && edges < 20) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      edges++;
    end
  endtask

  task automatic do_op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                       input logic bi, input logic [63:0] ed, input logic eb, input logic eo);
    int edges;
    int bc;
    a = av; b = bv; bin = bi; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(edges, bc);
    chk({tag, "_latency"}, 64'(edges), 64'd4);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_bout"}, {63'd0, bout}, {63'd0, eb});
    chk({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
  endtask

  initial begin
    int edges;
    int bc;
    int done_cnt;
    logic [63:0] seen;

    rst = 1'b1; start = 1'b0; a = 64'd0; b = 64'd0; bin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_diff", diff, 64'd0);
    chk("rst_flags", {59'd0, bout, ovf, busy, done, 1'b0}, 64'd0);

    // Basic op with latency and busy-width checks
    a = 64'd5; b = 64'd3; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy_after_accept", {63'd0, busy}, 64'd1);
    wait_done(edges, bc);
    chk("t1_latency", 64'(edges), 64'd4);
    chk("t1_busy_cycles", 64'(bc), 64'd4);
    chk("t1_diff", diff, 64'd2);
    chk("t1_bout_ovf", {62'd0, bout, ovf}, 64'd0);
    tick();
    chk("t1_done_one_cycle", {62'd0, done, busy}, 64'd0);
    chk("t1_diff_held", diff, 64'd2);

    do_op("t2", 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    tick();
    do_op("t3a", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    tick();
    do_op("t3b", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
          64'h8000_0000_0000_0000, 1'b1, 1'b1);
    tick();

    // Start during RUN and input changes must be ignored
    a = 64'd10; b = 64'd4; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 64'd100; b = 64'd1; start = 1'b1;
    tick();
    start = 1'b0; a = 64'd55; b = 64'd9; bin = 1'b1;
    done_cnt = 0;
    seen = 64'd0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) begin
        done_cnt++;
        seen = diff;
      end
      tick();
    end
    chk("t4_done_pulses", 64'(done_cnt), 64'd1);
    chk("t4_diff", seen, 64'd6);

    // Reset after two chunks aborts without a done pulse
    a = 64'd123; b = 64'd45; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_diff", diff, 64'd0);
    chk("t5_rst_busy_done", {62'd0, busy, done}, 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) done_cnt++;
      tick();
    end
    chk("t5_no_done", 64'(done_cnt), 64'd0);
    do_op("t5_after", 64'd7, 64'd7, 1'b0, 64'd0, 1'b0, 1'b0);
    tick();

    // Back-to-back: start in the DONE cycle of a prior op
    do_op("t6_first", 64'd20, 64'd5, 1'b0, 64'd15, 1'b0, 1'b0);
    a = 64'h1_0000; b = 64'd1; bin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_accept_busy_done", {62'd0, busy, done}, 64'd2);
    chk("t6_accept_diff_clear", diff, 64'd0);
    wait_done(edges, bc);
    chk("t6_latency", 64'(edges), 64'd4);
    chk("t6_diff", diff, 64'h0000_0000_0000_FFFE);
    chk("t6_bout_ovf", {62'd0, bout, ovf}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
